// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads a combinational instruction
// memory, and queues {pc, instr} pairs in a small FIFO for decode.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          DEPTH      = 2,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_busy_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int CNT_W = (DEPTH > 3) ? 3 : 2;
    localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT     = CNT_W'(DEPTH);
    localparam logic [31:0]      IMEM_WORDS_U = 32'(IMEM_WORDS);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_next;
    logic             fault_next;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [31:0]      buf_pc    [DEPTH];
    logic [31:0]      buf_instr [DEPTH];
    logic             in_range, pop, fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_range      = {2'b00, fetch_pc[31:2]} < IMEM_WORDS_U;
    // A redirect cycle hides the head so no stale entry can be handed over.
    assign instr_valid_o = (count != '0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign fire          = (state == RUN) && !redirect_i && !imem_busy_i && in_range
                           && ((count < FULL_CNT) || pop);

    assign imem_addr_o = fetch_pc;
    assign instr_o     = buf_instr[rd_ptr];
    assign pc_o        = buf_pc[rd_ptr];

    always_comb begin
        state_next = state;
        fault_next = fault_o;
        if (redirect_i) begin
            state_next = RUN;
            fault_next = 1'b0;
        end else if (state == RUN && !in_range) begin
            state_next = HALT;
            fault_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            fault_o  <= 1'b0;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state   <= state_next;
            fault_o <= fault_next;
            if (redirect_i) begin
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (fire && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !fire) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        if (fire) begin
            buf_pc[wr_ptr]    <= fetch_pc;
            buf_instr[wr_ptr] <= imem_instr_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table, hand sequences for fault/reset,
// then randomized traffic against a queue-based reference model.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0;
    localparam int          DEPTH      = 2;
    localparam int          IMEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        rst, busy, redir, ready;
    logic [31:0] rpc;
    logic [31:0] imem_addr, imem_instr, instr, pc;
    logic        valid, fault;

    // Memory word k holds the value k.
    assign imem_instr = {2'b00, imem_addr[31:2]};

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .IMEM_WORDS(IMEM_WORDS)) dut (
        .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
        .imem_busy_i(busy), .redirect_i(redir), .redirect_pc_i(rpc),
        .instr_valid_o(valid), .instr_ready_i(ready), .instr_o(instr), .pc_o(pc),
        .fault_o(fault)
    );

    typedef struct {
        logic        rst, busy, redir;
        logic [31:0] rpc;
        logic        ready, chk, ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic d, input logic [31:0] p,
                       input logic rd, input logic c, input logic ev, input logic [31:0] epc,
                       input logic ef, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.busy = b; v.redir = d; v.rpc = p; v.ready = rd;
        v.chk = c; v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = ea;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance.
    task automatic apply(input vec_t v);
        rst = v.rst; busy = v.busy; redir = v.redir; rpc = v.rpc; ready = v.ready;
        #1;
        if (v.chk) begin
            cmp("valid", {31'b0, valid}, {31'b0, v.ev});
            if (v.ev && valid) begin
                cmp("pc", pc, v.epc);
                cmp("instr", instr, v.epc >> 2);
            end
            cmp("fault", {31'b0, fault}, {31'b0, v.ef});
            cmp("addr", imem_addr, v.eaddr);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step(input logic r, input logic b, input logic d, input logic [31:0] p,
                        input logic rd, input logic c, input logic ev, input logic [31:0] epc,
                        input logic ef, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.busy = b; v.redir = d; v.rpc = p; v.ready = rd;
        v.chk = c; v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = ea;
        apply(v);
    endtask

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_pc;
    logic        m_halt, m_fault;

    initial begin
        rst = 1'b1; busy = 1'b0; redir = 1'b0; rpc = '0; ready = 1'b0;

        //   rst busy redir rpc      rdy chk ev  epc    ef  addr
        // Reset then streaming with ready=1
        add(1, 0, 0, 32'h0,  1, 0, 0, 32'h0,  0, 32'h0);
        add(1, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  0, 32'h4);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h4,  0, 32'h8);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h8,  0, 32'hC);
        // Backpressure: FIFO fills with pc 0,4 and fetch stalls at 8
        add(1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  0, 1, 1, 32'h0,  0, 32'h4);
        for (int i = 0; i < 6; i++)
            add(0, 0, 0, 32'h0, 0, 1, 1, 32'h0, 0, 32'h8);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  0, 32'h8);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h4,  0, 32'hC);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h8,  0, 32'h10);
        // Redirect to unaligned 0x13 while FIFO holds pc 0xC,0x10
        add(0, 0, 0, 32'h0,  0, 1, 1, 32'hC,  0, 32'h14);
        add(0, 0, 1, 32'h13, 1, 1, 0, 32'h0,  0, 32'h14);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h10);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h10, 0, 32'h14);
        add(0, 0, 0, 32'h0,  1, 1, 1, 32'h14, 0, 32'h18);
        // Memory busy on alternate cycles
        add(1, 0, 0, 32'h0,  1, 0, 0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h0);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h0);
        add(0, 1, 0, 32'h0,  1, 1, 1, 32'h0,  0, 32'h4);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h4);
        add(0, 1, 0, 32'h0,  1, 1, 1, 32'h4,  0, 32'h8);
        add(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h8);
        add(0, 1, 0, 32'h0,  1, 1, 1, 32'h8,  0, 32'hC);

        @(negedge clk);
        foreach (tbl[i]) apply(tbl[i]);

        // Run off the end of memory: 0x78, 0x7C delivered, then fault with no 0x80
        step(0, 0, 1, 32'h78, 1, 0, 0, 32'h0,  0, 32'h0);
        step(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h78);
        step(0, 0, 0, 32'h0,  1, 1, 1, 32'h78, 0, 32'h7C);
        step(0, 1, 0, 32'h0,  1, 1, 1, 32'h7C, 0, 32'h80);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 1, 32'h80);
        step(0, 0, 1, 32'h0,  1, 1, 0, 32'h0,  1, 32'h80);
        step(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, 32'h0);
        step(0, 0, 0, 32'h0,  1, 1, 1, 32'h0,  0, 32'h4);

        // Reset with FIFO full and fault set
        step(0, 0, 1, 32'h78, 0, 0, 0, 32'h0,  0, 32'h0);
        step(0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0, 32'h78);
        step(0, 0, 0, 32'h0,  0, 1, 1, 32'h78, 0, 32'h7C);
        step(0, 0, 0, 32'h0,  0, 1, 1, 32'h78, 0, 32'h80);
        step(1, 0, 0, 32'h0,  0, 1, 1, 32'h78, 1, 32'h80);
        step(0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0, RESET_PC);

        // Randomized traffic against the reference model, starting from reset
        mq.delete();
        for (int i = 0; i < 600; i++) begin
            logic        r, b, d, rd, ev, inr, pop_m, fire_m;
            logic [31:0] p;
            r  = (i == 0) || ($urandom_range(0, 59) == 0);
            d  = ($urandom_range(0, 11) == 0);
            p  = $urandom_range(0, IMEM_WORDS * 4 + 15);
            b  = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 2) != 0);
            rst = r; busy = b; redir = d; rpc = p; ready = rd;
            #1;
            if (i > 0) begin
                ev = (mq.size() != 0) && !d;
                cmp("rnd_valid", {31'b0, valid}, {31'b0, ev});
                if (ev && valid) begin
                    cmp("rnd_pc", pc, mq[0]);
                    cmp("rnd_instr", instr, mq[0] >> 2);
                end
                cmp("rnd_fault", {31'b0, fault}, {31'b0, m_fault});
                cmp("rnd_addr", imem_addr, m_pc);
            end else begin
                ev = 1'b0;
            end
            if (r) begin
                mq.delete(); m_pc = RESET_PC; m_halt = 1'b0; m_fault = 1'b0;
            end else if (d) begin
                mq.delete(); m_pc = p & ~32'd3; m_halt = 1'b0; m_fault = 1'b0;
            end else begin
                inr    = (m_pc >> 2) < IMEM_WORDS;
                pop_m  = ev && rd;
                fire_m = !m_halt && !b && inr && ((mq.size() < DEPTH) || pop_m);
                if (!m_halt && !inr) begin
                    m_halt = 1'b1; m_fault = 1'b1;
                end
                if (pop_m) void'(mq.pop_front());
                if (fire_m) begin
                    mq.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
